// File: rtl/rc5_key_expander.sv
// RC5 key-expansion engine: mixes the external S and L RAMs over 3*max(T,C) steps.
// Define KS_INIT_EN to also fill S with P_w + i*Q_w on chip before mixing.
module rc5_key_expander #(
    parameter  int W        = 32,
    parameter  int R        = 12,
    parameter  int C        = 4,
    localparam int T        = 2 * (R + 1),
    localparam int T_LENGTH = $clog2(T),
    // A single-word L table still needs a one-bit address port.
    localparam int C_LENGTH = (C > 1) ? $clog2(C) : 1,
    localparam int N        = 3 * ((T > C) ? T : C),
    localparam int LW       = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    output logic                oBusy,
    output logic                oDone,
    output logic [T_LENGTH-1:0] oS_address,
    input  logic [W-1:0]        iS_data,
    output logic [W-1:0]        oS_data,
    output logic                oS_we,
    output logic [C_LENGTH-1:0] oL_address,
    input  logic [W-1:0]        iL_data,
    output logic [W-1:0]        oL_data,
    output logic                oL_we
);

    localparam int KW = $clog2(N);

`ifdef KS_INIT_EN
    localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                  (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                              64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                  (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                              64'h9E37_79B9_7F4A_7C15;
    localparam logic [W-1:0] P_W = P64[W-1:0];
    localparam logic [W-1:0] Q_W = Q64[W-1:0];
`endif

    typedef enum logic [2:0] {
        IDLE,
`ifdef KS_INIT_EN
        INIT,
`endif
        RD,
        MIX_S,
        MIX_L,
        ADV,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [T_LENGTH-1:0]   i_q, i_d, i_next;
    logic [C_LENGTH-1:0]   j_q, j_d, j_next;
    logic [KW-1:0]         k_q, k_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [T_LENGTH-1:0]   s_addr_q, s_addr_d;
    logic [C_LENGTH-1:0]   l_addr_q, l_addr_d;
    logic [W-1:0]          s_data_q, s_data_d, l_data_q, l_data_d;
    logic                  s_we_q, s_we_d, l_we_q, l_we_d;
    logic [W-1:0]          sum_ab, mix_s_val, mix_l_val;
`ifdef KS_INIT_EN
    logic [W-1:0]          acc_q, acc_d;
`endif

    // Doubling the word makes the upper half a left rotate; a shift of 0 is identity.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    always_comb begin
        sum_ab    = a_q + b_q;
        mix_s_val = rotl(iS_data + sum_ab, LW'(3));
        mix_l_val = rotl(iL_data + sum_ab, sum_ab[LW-1:0]);
        i_next    = (i_q == T_LENGTH'(T - 1)) ? '0 : i_q + T_LENGTH'(1);
        j_next    = (j_q == C_LENGTH'(C - 1)) ? '0 : j_q + C_LENGTH'(1);
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        s_addr_d = s_addr_q;
        l_addr_d = l_addr_q;
        s_data_d = s_data_q;
        l_data_d = l_data_q;
        s_we_d   = 1'b0;
        l_we_d   = 1'b0;
`ifdef KS_INIT_EN
        acc_d    = acc_q;
`endif
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    busy_d   = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    a_d      = '0;
                    b_d      = '0;
                    s_addr_d = '0;
                    l_addr_d = '0;
`ifdef KS_INIT_EN
                    state_d  = INIT;
                    s_we_d   = 1'b1;
                    s_data_d = P_W;
                    acc_d    = P_W + Q_W;
`else
                    state_d  = RD;
`endif
                end
            end
`ifdef KS_INIT_EN
            // Outputs run one word ahead so each INIT cycle shows its own write.
            INIT: begin
                if (i_q == T_LENGTH'(T - 1)) begin
                    i_d      = '0;
                    s_addr_d = '0;
                    state_d  = RD;
                end else begin
                    i_d      = i_q + T_LENGTH'(1);
                    s_addr_d = i_q + T_LENGTH'(1);
                    s_data_d = acc_q;
                    s_we_d   = 1'b1;
                    acc_d    = acc_q + Q_W;
                end
            end
`endif
            RD: state_d = MIX_S;
            MIX_S: begin
                a_d      = mix_s_val;
                s_data_d = mix_s_val;
                s_we_d   = 1'b1;
                state_d  = MIX_L;
            end
            MIX_L: begin
                b_d      = mix_l_val;
                l_data_d = mix_l_val;
                l_we_d   = 1'b1;
                state_d  = ADV;
            end
            ADV: begin
                i_d      = i_next;
                j_d      = j_next;
                k_d      = k_q + KW'(1);
                s_addr_d = i_next;
                l_addr_d = j_next;
                state_d  = (k_q == KW'(N - 1)) ? DONE : RD;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            s_addr_q <= '0;
            l_addr_q <= '0;
            s_data_q <= '0;
            l_data_q <= '0;
            s_we_q   <= 1'b0;
            l_we_q   <= 1'b0;
`ifdef KS_INIT_EN
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            s_addr_q <= s_addr_d;
            l_addr_q <= l_addr_d;
            s_data_q <= s_data_d;
            l_data_q <= l_data_d;
            s_we_q   <= s_we_d;
            l_we_q   <= l_we_d;
`ifdef KS_INIT_EN
            acc_q    <= acc_d;
`endif
        end
    end

    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oS_address = s_addr_q;
    assign oS_data    = s_data_q;
    assign oS_we      = s_we_q;
    assign oL_address = l_addr_q;
    assign oL_data    = l_data_q;
    assign oL_we      = l_we_q;

endmodule
